frame_scan_ctrl: RTL
====================

// Module: frame_scan_ctrl
// PURPOSE
//  Sequencer that scans a colour framebuffer RAM in raster order and streams
//  (x, y, colour) plot requests to the VGA adapter, one pixel per accepted beat.
//  Sits between the pixel-memory datapath and the VGA adapter's plot port.
//  Started by a one-cycle start pulse; reports busy and a done pulse.
// PARAMETERS
//  H_RES     160  pixels per line
//  V_RES     120  lines per frame
//  X_W       8    x coordinate width, at least clog2(H_RES)
//  Y_W       7    y coordinate width, at least clog2(V_RES)
//  COLOUR_W  3    colour width
//  ADDR_W    15   RAM address width, at least clog2(H_RES*V_RES)
// PORTS
//  Clock       in   1         rising-edge clock
//  Resetn      in   1         asynchronous, active-low reset
//  start       in   1         one-cycle pulse: begin a frame scan
//  abort       in   1         synchronous abort of the scan in progress
//  mem_rd      out  1         RAM read enable
//  mem_addr    out  ADDR_W    RAM address = y*H_RES + x
//  mem_rdata   in   COLOUR_W  RAM data
//  plot_ready  in   1         adapter accepts the current beat when high
//  plot        out  1         x/y/colour are valid
//  x           out  X_W       pixel column
//  y           out  Y_W       pixel row
//  colour      out  COLOUR_W  pixel colour
//  busy        out  1         scan in progress
//  done        out  1         one-cycle pulse: frame complete
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; counters 0. Reset mid-scan aborts immediately.
//  RAM contract: mem_rdata is valid the cycle after mem_rd=1 and holds while mem_rd=0.
//  FSM states:
//   IDLE: start=1 -> SCAN with counters at (0,0); busy goes high next cycle.
//   SCAN: counters advance while there is no stall.
//   DRAIN: last address issued; wait until the pipeline is empty.
//   DONE: done=1 for one cycle; busy=0; -> IDLE.
//  Stall: adv = !plot | plot_ready. All pipeline registers, counters and mem_rd gate on adv.
//  Pipeline, 2 stages:
//   - S0 issues mem_rd/mem_addr for (xc,yc) and latches xc,yc into S1 with s1_v.
//   - S1 loads x, y, colour<=mem_rdata and plot<=s1_v into the output regs.
//  Latency: first plot asserts 2 cycles after start is sampled, given plot_ready=1.
//  Counters: xc wraps H_RES-1 -> 0 and then yc increments.
//   - Last address is (H_RES-1, V_RES-1); the SCAN -> DRAIN transition occurs on it.
//   - No address beyond H_RES*V_RES-1 is ever issued.
//  Throughput: 1 pixel/cycle with plot_ready held high; exactly H_RES*V_RES plot beats per frame.
//  plot stays high with x/y/colour stable until plot_ready=1 (valid/ready hold rule).
//  Frame end: done pulses the cycle after the final beat is accepted.
//  start while busy: ignored; no restart.
//  start and abort in the same cycle while IDLE: abort wins; stay IDLE.
//  abort while busy: next cycle -> IDLE with plot=0, mem_rd=0, busy=0 and no done pulse.
//   - Dropping plot mid-handshake is legal only on abort.
//  Arithmetic: mem_addr is computed from a running row base (+H_RES per line) plus xc.
//   - No multiplier; all sums are zero-extended to ADDR_W.
// CONFIGURATION
//  SKIP_BLACK_EN defined: a beat whose colour==0 is dropped.
//   - It is not presented; plot stays 0 and the pipeline advances without needing plot_ready.
//   - done still fires after the last pixel is processed.
//  SKIP_BLACK_EN undefined: every pixel, including colour 0, is plotted.
// TESTING  (H_RES=4, V_RES=3 unless noted; RAM model addr->addr%8)
//  1. Reset low mid-frame:
//   - All outputs 0 asynchronously.
//   - Resetn high, then start -> scan restarts at (0,0).
//  2. start, plot_ready=1:
//   - 12 beats in raster order (0,0)..(3,2) with colour=addr%8.
//   - First plot at cycle 2 after start; done one cycle after beat 12; busy high throughout.
//  3. plot_ready low for 3 cycles at beat (1,1):
//   - x=1, y=1, colour=5 held stable; no beat lost or duplicated; still 12 beats.
//  4. start pulsed again at beat 6: ignored; exactly 12 beats and a single done.
//  5. abort at beat 5: plot=0 and busy=0 next cycle; no done; a new start yields a full 12-beat frame.
//  6. SKIP_BLACK_EN defined: addresses 0 and 8 are not plotted; 10 beats; done fires.

Source files
------------

// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: raster-order framebuffer scanner that feeds (x, y, colour)
// plot beats to the VGA adapter through a two-stage valid/ready pipeline.
// Optional build macro: SKIP_BLACK_EN. When it is defined, pixels whose colour
// is 0 are dropped instead of plotted.
module frame_scan_ctrl #(
  parameter int H_RES    = 160,
  parameter int V_RES    = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W   = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                mem_rd_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic [COLOUR_W-1:0] mem_rdata_i,
  input  logic                plot_ready_i,
  output logic                plot_o,
  output logic [X_W-1:0]      x_o,
  output logic [Y_W-1:0]      y_o,
  output logic [COLOUR_W-1:0] colour_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [X_W-1:0]    X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  state_t                state_q;

  // Issue stage: coordinates and address currently presented to the RAM.
  logic                  rd_q;
  logic [X_W-1:0]        xc_q, xc_d;
  logic [Y_W-1:0]        yc_q, yc_d;
  logic [ADDR_W-1:0]     row_base_q, row_base_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;

  // Second stage: coordinates waiting for their RAM data.
  logic                  s1_v_q;
  logic [X_W-1:0]        s1_x_q;
  logic [Y_W-1:0]        s1_y_q;

  // Output stage registers.
  logic                  plot_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [COLOUR_W-1:0]   colour_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  adv;
  logic                  last_x;
  logic                  last_pix;
  logic                  drain_empty;
  logic                  beat_visible;
  logic                  abort_busy;

  // Stall detection, end-of-line/frame flags and the next raster position,
  // with the address built from a running row base instead of a multiply.
  always_comb begin
    adv         = !plot_q || plot_ready_i;
    last_x      = (xc_q == X_LAST);
    last_pix    = last_x && (yc_q == Y_LAST);
    drain_empty = !rd_q && !s1_v_q && (!plot_q || plot_ready_i);
    abort_busy  = abort_i && ((state_q == SCAN) || (state_q == DRAIN));
    xc_d        = xc_q + 1'b1;
    yc_d        = yc_q;
    row_base_d  = row_base_q;
    if (last_x) begin
      xc_d       = '0;
      yc_d       = yc_q + 1'b1;
      row_base_d = row_base_q + ROW_STEP;
    end
    addr_d = row_base_d + ADDR_W'(xc_d);
`ifdef SKIP_BLACK_EN
    beat_visible = s1_v_q && (mem_rdata_i != '0);
`else
    beat_visible = s1_v_q;
`endif
  end

  // The RAM read is qualified by adv so that its data register holds the
  // pixel still waiting in stage 1 while the adapter stalls us.
  assign mem_rd_o   = rd_q && adv;
  assign mem_addr_o = addr_q;
  assign plot_o     = plot_q;
  assign x_o        = x_q;
  assign y_o        = y_q;
  assign colour_o   = colour_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  // Sequencer FSM together with the pipeline and raster counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rd_q       <= 1'b0;
      xc_q       <= '0;
      yc_q       <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      s1_v_q     <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      plot_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort_busy) begin
      state_q  <= IDLE;
      rd_q     <= 1'b0;
      s1_v_q   <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (adv) begin
        s1_v_q   <= rd_q;
        s1_x_q   <= xc_q;
        s1_y_q   <= yc_q;
        plot_q   <= beat_visible;
        x_q      <= s1_x_q;
        y_q      <= s1_y_q;
        colour_q <= mem_rdata_i;
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i && !abort_i) begin
            state_q    <= SCAN;
            rd_q       <= 1'b1;
            xc_q       <= '0;
            yc_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b1;
          end
        end
        SCAN: begin
          if (adv) begin
            if (last_pix) begin
              rd_q    <= 1'b0;
              state_q <= DRAIN;
            end else begin
              xc_q       <= xc_d;
              yc_q       <= yc_d;
              row_base_q <= row_base_d;
              addr_q     <= addr_d;
            end
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
